// File: rtl/busperm_sched.sv
// busperm_sched: round-robin front end for a shared combinational lane
// permutator. Stage S1 holds the granted request and drives the permutator.
// Stage S2 captures the permutator result and presents it downstream with
// valid/ready handshaking.
module busperm_sched #(
  parameter int NREQ  = 4,
  parameter int LANES = 8,
  parameter int LW    = 4,
  parameter int CW    = 16,
  localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1,
  localparam int DW   = LANES * LW
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*CW-1:0]   req_ctrl,
  input  logic [NREQ*DW-1:0]   req_data,
  output logic [CW-1:0]        perm_ctrl,
  output logic [DW-1:0]        perm_din,
  input  logic [DW-1:0]        perm_dout,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DW-1:0]        out_data,
  output logic [IDW-1:0]       out_id,
  output logic                 busy,
  output logic [15:0]          accept_cnt
);

  // Stage S1: request feeding the permutator
  logic            v1_reg;
  logic [IDW-1:0]  id1_reg;
  logic [CW-1:0]   perm_ctrl_reg;
  logic [DW-1:0]   perm_din_reg;
  // Stage S2: captured result
  logic            out_valid_reg;
  logic [DW-1:0]   out_data_reg;
  logic [IDW-1:0]  out_id_reg;
  // Arbitration pointer and accept counter
  logic [IDW-1:0]  ptr_reg;
  logic [15:0]     accept_cnt_reg;

  // Per-requester views of the flat request buses
  logic [CW-1:0]   ctrl_arr [NREQ];
  logic [DW-1:0]   data_arr [NREQ];

  logic            s2_free;
  logic            s1_adv;
  logic [NREQ-1:0] rot_valid;
  logic            grant_found;
  logic [IDW-1:0]  grant_off;
  logic [IDW:0]    grant_sum;
  logic [IDW-1:0]  grant_idx;
  logic            accept;

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_slice
      assign ctrl_arr[gi] = req_ctrl[gi*CW +: CW];
      assign data_arr[gi] = req_data[gi*DW +: DW];
    end
  endgenerate

  // S2 drains when empty or being consumed; S1 moves when empty or S2 drains.
  assign s2_free = ~out_valid_reg | out_ready;
  assign s1_adv  = ~v1_reg | s2_free;

  // Rotate the request vector so bit k is requester (ptr + k) mod NREQ.
  assign rot_valid = NREQ'({req_valid, req_valid} >> ptr_reg);

  // Find the lowest rotated offset with a pending request.
  always_comb begin
    grant_found = 1'b0;
    grant_off   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (rot_valid[k]) begin
        grant_found = 1'b1;
        grant_off   = k[IDW-1:0];
      end
    end
  end

  // Map the rotated offset back to an absolute requester index.
  always_comb begin
    grant_sum = {1'b0, ptr_reg} + {1'b0, grant_off};
    if (grant_sum >= (IDW+1)'(NREQ)) begin
      grant_sum = grant_sum - (IDW+1)'(NREQ);
    end
    grant_idx = grant_sum[IDW-1:0];
  end

  // Reset blocks any accept so the reset cycle never loads S1.
  assign accept = grant_found & s1_adv & ~rst;

  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_ready
      assign req_ready[gi] = accept & (grant_idx == IDW'(gi));
    end
  endgenerate

  // S1 register: load on accept, otherwise empty out when it advances.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_reg        <= 1'b0;
      id1_reg       <= '0;
      perm_ctrl_reg <= '0;
      perm_din_reg  <= '0;
    end else if (s1_adv) begin
      v1_reg <= accept;
      if (accept) begin
        id1_reg       <= grant_idx;
        perm_ctrl_reg <= ctrl_arr[grant_idx];
        perm_din_reg  <= data_arr[grant_idx];
      end
    end
  end

  // S2 register: take the permutator result whenever the slot is free;
  // a stalled result holds untouched until out_ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_id_reg    <= '0;
    end else if (s2_free) begin
      out_valid_reg <= v1_reg;
      if (v1_reg) begin
        out_data_reg <= perm_dout;
        out_id_reg   <= id1_reg;
      end
    end
  end

  // Round-robin pointer and accept counter move only on an accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_reg        <= '0;
      accept_cnt_reg <= '0;
    end else if (accept) begin
      ptr_reg        <= (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
      accept_cnt_reg <= accept_cnt_reg + 16'd1;
    end
  end

  assign perm_ctrl  = perm_ctrl_reg;
  assign perm_din   = perm_din_reg;
  assign out_valid  = out_valid_reg;
  assign out_data   = out_data_reg;
  assign out_id     = out_id_reg;
  assign busy       = v1_reg | out_valid_reg;
  assign accept_cnt = accept_cnt_reg;

endmodule

// File: tb/tb_busperm_sched.sv
// Bench for busperm_sched: hand-derived vector table, backpressure and
// counter-wrap sequences, then randomized traffic against a reference model.
module tb_busperm_sched;
  localparam int NREQ  = 4;
  localparam int LANES = 8;
  localparam int LW    = 4;
  localparam int CW    = 16;
  localparam int DW    = LANES * LW;

  logic                clk = 1'b0;
  logic                rst;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ-1:0]     req_ready;
  logic [NREQ*CW-1:0]  req_ctrl;
  logic [NREQ*DW-1:0]  req_data;
  logic [CW-1:0]       perm_ctrl;
  logic [DW-1:0]       perm_din;
  logic [DW-1:0]       perm_dout;
  logic                out_valid;
  logic                out_ready;
  logic [DW-1:0]       out_data;
  logic [1:0]          out_id;
  logic                busy;
  logic [15:0]         accept_cnt;

  int n_vec = 0;
  int n_bad = 0;

  busperm_sched #(.NREQ(NREQ), .LANES(LANES), .LW(LW), .CW(CW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_ctrl(req_ctrl), .req_data(req_data),
    .perm_ctrl(perm_ctrl), .perm_din(perm_din), .perm_dout(perm_dout),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_id(out_id),
    .busy(busy), .accept_cnt(accept_cnt)
  );

  always #5 clk = ~clk;

  // Stand-in permutator: output lane j = input lane (j xor ctrl[2:0]) xor ctrl[7:4].
  function automatic logic [DW-1:0] perm_fn(input logic [CW-1:0] c, input logic [DW-1:0] d);
    logic [DW-1:0] r;
    int s;
    r = '0;
    for (int j = 0; j < LANES; j++) begin
      s = j ^ int'(c[2:0]);
      r[j*LW +: LW] = d[s*LW +: LW] ^ c[7:4];
    end
    return r;
  endfunction

  always_comb perm_dout = perm_fn(perm_ctrl, perm_din);

  // Reference model state
  bit              m_v1, m_ov;
  logic [CW-1:0]   m_pc;
  logic [DW-1:0]   m_pd, m_od;
  int              m_id1, m_oid, m_ptr;
  logic [15:0]     m_cnt;
  logic [NREQ-1:0] pre_rdy;

  function automatic int model_grant();
    int i;
    for (int k = 0; k < NREQ; k++) begin
      i = (m_ptr + k) % NREQ;
      if (req_valid[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic [NREQ-1:0] model_ready();
    bit s2free, s1adv;
    int g;
    if (rst) return '0;
    s2free = !m_ov || out_ready;
    s1adv  = !m_v1 || s2free;
    g = model_grant();
    if (g >= 0 && s1adv) return NREQ'(1) << g;
    return '0;
  endfunction

  task automatic model_step();
    bit s2free, s1adv;
    int g;
    if (rst) begin
      m_v1 = 0; m_ov = 0; m_pc = '0; m_pd = '0; m_od = '0;
      m_id1 = 0; m_oid = 0; m_ptr = 0; m_cnt = '0;
    end else begin
      s2free = !m_ov || out_ready;
      s1adv  = !m_v1 || s2free;
      g = model_grant();
      if (s2free) begin
        if (m_v1) begin
          m_od  = perm_fn(m_pc, m_pd);
          m_oid = m_id1;
        end
        m_ov = m_v1;
      end
      if (s1adv) begin
        if (g >= 0) begin
          m_pc  = req_ctrl[g*CW +: CW];
          m_pd  = req_data[g*DW +: DW];
          m_id1 = g;
          m_ptr = (g + 1) % NREQ;
          m_cnt = m_cnt + 16'd1;
          m_v1  = 1;
        end else begin
          m_v1 = 0;
        end
      end
    end
  endtask

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // One clock: drive at negedge, check combinational ready, step the model
  // at the edge, then check registered outputs just after it.
  task automatic cycle(input logic r, input logic [NREQ-1:0] rv, input logic ordy, input bit chk);
    @(negedge clk);
    rst = r; req_valid = rv; out_ready = ordy;
    #1;
    pre_rdy = req_ready;
    if (chk) check("req_ready", 64'(req_ready), 64'(model_ready()));
    @(posedge clk);
    model_step();
    #1;
    if (chk) begin
      check("out_valid",  64'(out_valid),  64'(m_ov));
      check("out_id",     64'(out_id),     64'(m_oid));
      check("out_data",   64'(out_data),   64'(m_od));
      check("perm_ctrl",  64'(perm_ctrl),  64'(m_pc));
      check("perm_din",   64'(perm_din),   64'(m_pd));
      check("busy",       64'(busy),       64'(m_v1 | m_ov));
      check("accept_cnt", 64'(accept_cnt), 64'(m_cnt));
    end
  endtask

  typedef struct {
    logic            r;
    logic [NREQ-1:0] rv;
    logic            ordy;
    logic [NREQ-1:0] exp_rdy;
    logic            exp_ov;
    logic [1:0]      exp_oid;
    logic [15:0]     exp_cnt;
  } vec_t;

  vec_t tbl [16];
  int   acc;

  initial begin
    rst = 1'b1; req_valid = '0; out_ready = 1'b1;
    req_ctrl = '0; req_data = '0;
    m_v1 = 0; m_ov = 0; m_pc = '0; m_pd = '0; m_od = '0;
    m_id1 = 0; m_oid = 0; m_ptr = 0; m_cnt = '0;

    // Hand-derived expectations: req_ready before the edge, state after it.
    tbl[0]  = '{1'b1, 4'b1111, 1'b1, 4'b0000, 1'b0, 2'd0, 16'd0};
    tbl[1]  = '{1'b0, 4'b0001, 1'b1, 4'b0001, 1'b0, 2'd0, 16'd1};
    tbl[2]  = '{1'b0, 4'b0000, 1'b1, 4'b0000, 1'b1, 2'd0, 16'd1};
    tbl[3]  = '{1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 16'd1};
    tbl[4]  = '{1'b0, 4'b1111, 1'b1, 4'b0010, 1'b0, 2'd0, 16'd2};
    tbl[5]  = '{1'b0, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd1, 16'd3};
    tbl[6]  = '{1'b0, 4'b1111, 1'b1, 4'b1000, 1'b1, 2'd2, 16'd4};
    tbl[7]  = '{1'b0, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd3, 16'd5};
    tbl[8]  = '{1'b0, 4'b1111, 1'b0, 4'b0000, 1'b1, 2'd3, 16'd5};
    tbl[9]  = '{1'b0, 4'b1111, 1'b0, 4'b0000, 1'b1, 2'd3, 16'd5};
    tbl[10] = '{1'b0, 4'b0100, 1'b1, 4'b0100, 1'b1, 2'd0, 16'd6};
    tbl[11] = '{1'b0, 4'b0001, 1'b1, 4'b0001, 1'b1, 2'd2, 16'd7};
    tbl[12] = '{1'b0, 4'b0010, 1'b1, 4'b0010, 1'b1, 2'd0, 16'd8};
    tbl[13] = '{1'b1, 4'b1111, 1'b1, 4'b0000, 1'b0, 2'd0, 16'd0};
    tbl[14] = '{1'b0, 4'b1111, 1'b1, 4'b0001, 1'b0, 2'd0, 16'd1};
    tbl[15] = '{1'b0, 4'b0000, 1'b1, 4'b0000, 1'b1, 2'd0, 16'd1};

    req_ctrl = {16'h0F27, 16'h00A6, 16'h1153, 16'h0000};
    req_data = {32'hFEDCBA98, 32'h01234567, 32'h89ABCDEF, 32'h76543210};

    for (int i = 0; i < 16; i++) begin
      cycle(tbl[i].r, tbl[i].rv, tbl[i].ordy, 1'b1);
      check($sformatf("tbl%0d_ready", i), 64'(pre_rdy), 64'(tbl[i].exp_rdy));
      check($sformatf("tbl%0d_valid", i), 64'(out_valid), 64'(tbl[i].exp_ov));
      if (tbl[i].exp_ov)
        check($sformatf("tbl%0d_id", i), 64'(out_id), 64'(tbl[i].exp_oid));
      check($sformatf("tbl%0d_cnt", i), 64'(accept_cnt), 64'(tbl[i].exp_cnt));
    end

    // Backpressure: 0101 pending with out_ready low for five cycles.
    cycle(1'b1, 4'b0000, 1'b1, 1'b1);
    acc = 0;
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 4'b0101, 1'b0, 1'b1);
      acc += $countones(pre_rdy & 4'b0101);
    end
    check("bp_accepts", 64'(acc), 64'd2);
    check("bp_held_valid", 64'(out_valid), 64'd1);
    check("bp_held_id", 64'(out_id), 64'd0);
    check("bp_held_ctrl", 64'(perm_ctrl), 64'(req_ctrl[2*CW +: CW]));
    cycle(1'b0, 4'b0000, 1'b1, 1'b1);
    check("bp_release_id", 64'(out_id), 64'd2);
    check("bp_release_valid", 64'(out_valid), 64'd1);

    // Counter wrap: 0xFFFF accepts at full rate, then one more.
    cycle(1'b1, 4'b0000, 1'b1, 1'b1);
    for (int i = 0; i < 65535; i++) cycle(1'b0, 4'b1111, 1'b1, 1'b0);
    check("wrap_ffff", 64'(accept_cnt), 64'hFFFF);
    cycle(1'b0, 4'b1111, 1'b1, 1'b1);
    check("wrap_zero", 64'(accept_cnt), 64'h0000);

    // Randomized traffic against the model, with occasional resets.
    for (int i = 0; i < 600; i++) begin
      req_ctrl = {$urandom, $urandom};
      req_data = {$urandom, $urandom, $urandom, $urandom};
      cycle(($urandom % 50) == 0, NREQ'($urandom), ($urandom % 4) != 0, 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/busperm_sched.md
BUSPERM_SCHED -- requirements
Module: busperm_sched

Interface
REQ-001 The block SHALL have parameter NREQ, default 4: number of requesters.
REQ-002 The block SHALL have parameter LANES, default 8: number of permutator lanes.
REQ-003 The block SHALL have parameter LW, default 4: bits per lane.
REQ-004 The block SHALL have parameter CW, default 16: permutator control word width.
REQ-005 The block SHALL have port clk, input, 1 bit: single clock; all state on rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-007 The block SHALL have port req_valid, input, NREQ bits: per-requester request.
REQ-008 The block SHALL have port req_ready, output, NREQ bits: per-requester accept, at most one bit set.
REQ-009 The block SHALL have port req_ctrl, input, NREQ*CW bits: control word; requester i at slice [i*CW +: CW].
REQ-010 The block SHALL have port req_data, input, NREQ*LANES*LW bits: lane data per requester, same slicing.
REQ-011 The block SHALL have port perm_ctrl, output, CW bits: registered control to permutator.
REQ-012 The block SHALL have port perm_din, output, LANES*LW bits: registered data to permutator.
REQ-013 The block SHALL have port perm_dout, input, LANES*LW bits: combinational permutator result.
REQ-014 The block SHALL have port out_valid, output, 1 bit: result valid.
REQ-015 The block SHALL have port out_ready, input, 1 bit: downstream accept.
REQ-016 The block SHALL have port out_data, output, LANES*LW bits: captured permutator result.
REQ-017 The block SHALL have port out_id, output, clog2(NREQ) bits: requester index of out_data.
REQ-018 The block SHALL have port busy, output, 1 bit: high when either pipeline stage is occupied.
REQ-019 The block SHALL have port accept_cnt, output, 16 bits: count of accepted requests, wrapping 0xFFFF->0x0000.

Function
REQ-020 The block SHALL use two pipeline stages: S1 (perm_ctrl/perm_din/id/v1) and S2 (out_data/out_id/out_valid).
REQ-021 S2 SHALL be free when out_valid=0 or out_ready=1; S1 SHALL advance when v1=0 or S2 is free.
REQ-022 Arbitration SHALL be round-robin from pointer ptr: grant the first i in ptr, ptr+1, ... (mod NREQ) with req_valid[i]=1.
REQ-023 req_ready[g] SHALL be 1 only for the granted g and only when S1 advances; all other bits SHALL be 0.
REQ-024 Accept (req_valid[g]&req_ready[g]) SHALL load S1 with req_ctrl[g], req_data[g] and id=g, set v1=1, set ptr=(g+1) mod NREQ, and increment accept_cnt.
REQ-025 Without an accept, ptr SHALL hold, and v1 SHALL clear if S1 advances.
REQ-026 When S1 advances and v1=1, S2 SHALL capture perm_dout into out_data and id into out_id with out_valid=1; if v1=0, out_valid SHALL clear.
REQ-027 Latency SHALL be: accept at edge N gives out_valid=1 after edge N+1, with no backpressure.
REQ-028 Throughput SHALL be one result per cycle when out_ready=1 continuously.
REQ-029 While out_valid=1 and out_ready=0, out_data, out_id, S1 and ptr SHALL hold, and req_ready SHALL be all 0 if v1=1.
REQ-030 perm_ctrl/perm_din SHALL change only on an accept, so the permutator input stays stable while its result waits.
REQ-031 req_valid may drop without an accept; this SHALL have no side effects.
REQ-032 busy SHALL equal v1|out_valid.

Reset
REQ-033 When rst=1 at a clock edge, the block SHALL set v1=0, out_valid=0, ptr=0, accept_cnt=0, perm_ctrl=0, perm_din=0, out_data=0 and out_id=0.
REQ-034 While rst=1, req_ready SHALL be all 0.
REQ-035 rst asserted mid-operation SHALL drop in-flight results without emitting them, with no accept in the reset cycle.
REQ-036 Normal operation SHALL resume on the first edge with rst=0.

Verification
REQ-037 Single request: req_valid=0001, ctrl=0x0000, out_ready=1 -> req_ready=0001 for one cycle; out_valid one cycle later with out_data=perm_dout(ctrl 0x0000), out_id=0, accept_cnt=1.
REQ-038 All four requesting every cycle, out_ready=1 -> grants 0,1,2,3,0,1,...; out_id follows the same sequence; one result per cycle.
REQ-039 Backpressure: out_ready=0 for 5 cycles with 0101 pending -> out_valid held; out_data/out_id/perm_ctrl stable; at most 2 accepts; order resumes 0,2 after release.
REQ-040 Pointer skip: ptr=2 with only req_valid=0001 -> grant 0, ptr becomes 1.
REQ-041 Reset mid-burst: rst=1 for 1 cycle with S1 and S2 full -> out_valid=0, busy=0, accept_cnt=0, ptr=0; next grant goes to requester 0.
REQ-042 Wrap: preload 0xFFFF accepts (or force) and then one more accept -> accept_cnt=0x0000.
